// File: rtl/ahb_pkg.sv
// Shared AHB encodings, bridge FSM states and burst helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_t;

  // 0 means an unbounded burst (SINGLE / INCR).
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] beats;
    beats = 5'd0;
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  beats = 5'd4;
      BURST_WRAP8,  BURST_INCR8:  beats = 5'd8;
      BURST_WRAP16, BURST_INCR16: beats = 5'd16;
      default:                    beats = 5'd0;
    endcase
    return beats;
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
  endfunction

  function automatic logic [6:0] size_mask(input logic [2:0] size);
    return (7'd1 << size) - 7'd1;
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Burst tracker: expected next address and remaining beat count of the open burst.
// Latency: state updates on the accepting edge; next_addr is registered.
// Backpressure: none; load/advance are qualified by the caller.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      load,
  input  logic                      advance,
  input  logic                      abort,
  input  logic [AHB_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]                burst,
  input  logic [2:0]                size,
  output logic                      burst_open,
  output logic [AHB_ADDR_WIDTH-1:0] next_addr
);

  localparam int AW = AHB_ADDR_WIDTH;

  logic          open_q;
  logic          bounded_q;
  logic [4:0]    cnt_q;
  logic [2:0]    burst_q;
  logic [2:0]    size_q;
  logic [AW-1:0] next_q;

  logic [2:0]    cur_burst;
  logic [2:0]    cur_size;
  logic [4:0]    cur_beats;
  logic [AW-1:0] step;
  logic [AW-1:0] incr;
  logic [AW-1:0] wmask;
  logic [AW-1:0] nxt;

  // A NONSEQ brings its own burst/size; SEQ beats reuse the ones captured at the NONSEQ.
  always_comb begin
    cur_burst = load ? burst : burst_q;
    cur_size  = load ? size  : size_q;
    cur_beats = burst_beats(cur_burst);
    step      = AW'(1) << cur_size;
    incr      = addr + step;
    wmask     = (AW'(cur_beats) << cur_size) - AW'(1);
    nxt       = is_wrap(cur_burst) ? ((addr & ~wmask) | (incr & wmask)) : incr;
  end

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      open_q    <= 1'b0;
      bounded_q <= 1'b0;
      cnt_q     <= 5'd0;
      burst_q   <= 3'd0;
      size_q    <= 3'd0;
      next_q    <= '0;
    end else if (abort) begin
      open_q <= 1'b0;
    end else if (load) begin
      open_q    <= 1'b1;
      burst_q   <= burst;
      size_q    <= size;
      bounded_q <= (cur_beats != 5'd0);
      cnt_q     <= cur_beats - 5'd1;
      next_q    <= nxt;
    end else if (advance && open_q) begin
      next_q <= nxt;
      if (bounded_q) begin
        if (cnt_q == 5'd1) open_q <= 1'b0;
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

  assign burst_open = open_q;
  assign next_addr  = next_q;

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB slave to NUM_CH back-end channels; optional wait timeout under AHB_BRIDGE_TIMEOUT_EN.
// Latency: one address-phase edge, then back-end wait cycles; errors take two cycles.
// Backpressure: HREADYOUT low while the selected channel is not ready.
module ahb_slave_bridge
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int NUM_CH           = 2,
  parameter int CH_SEL_LSB       = 12,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                             ahb_clk_in,
  input  logic                             ahb_rstn_in,
  input  logic                             ahb_sel_in,
  input  logic                             ahb_readyin_in,
  input  logic [1:0]                       ahb_trans_in,
  input  logic [2:0]                       ahb_burst_in,
  input  logic [2:0]                       ahb_size_in,
  input  logic                             ahb_write_in,
  input  logic [AHB_ADDR_WIDTH-1:0]        ahb_addr_in,
  input  logic [AHB_DATA_WIDTH-1:0]        ahb_wdata_in,
  output logic [AHB_DATA_WIDTH-1:0]        ahb_rdata_out,
  output logic                             ahb_ready_out,
  output logic                             ahb_resp_out,
  output logic [NUM_CH-1:0]                other_sel_out,
  output logic [AHB_ADDR_WIDTH-1:0]        other_addr_out,
  output logic                             other_write_out,
  output logic [2:0]                       other_size_out,
  output logic [AHB_DATA_WIDTH-1:0]        other_wdata_out,
  input  logic [NUM_CH*AHB_DATA_WIDTH-1:0] other_rdata_in,
  input  logic [NUM_CH-1:0]                other_ready_in,
  input  logic [NUM_CH-1:0]                other_error_in
);

  localparam int AW       = AHB_ADDR_WIDTH;
  localparam int DW       = AHB_DATA_WIDTH;
  localparam int MAX_SIZE = $clog2(DW / 8);

  state_t        state_q, state_d;
  logic [2:0]    ch_q;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [DW-1:0] wdata_q;
  logic          first_q;

  logic          sel_ready, sel_err;
  logic [DW-1:0] sel_rdata;
  logic          done_ok, done_err, timeout;
  logic          can_accept, hit, acc, illegal, legal;
  logic [AW-1:0] ch_upper;
  logic          burst_open;
  logic [AW-1:0] exp_addr;

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 3'(c)) begin
        sel_ready = other_ready_in[c];
        sel_err   = other_error_in[c];
        sel_rdata = other_rdata_in[c*DW +: DW];
      end
    end
  end

  assign done_ok  = (state_q == ST_ACCESS) && sel_ready && !sel_err;
  assign done_err = (state_q == ST_ACCESS) && sel_ready && sel_err;

`ifdef AHB_BRIDGE_TIMEOUT_EN
  localparam int WCW = $clog2(AHB_WAIT_TIMEOUT + 1);
  logic [WCW-1:0] wait_q;

  assign timeout = (state_q == ST_ACCESS) && !sel_ready &&
                   (wait_q == WCW'(AHB_WAIT_TIMEOUT - 1));

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in)                             wait_q <= '0;
    else if ((state_q == ST_ACCESS) && !sel_ready) wait_q <= wait_q + WCW'(1);
    else                                          wait_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  // Everything above the channel field counts toward the index, so unmapped space errors.
  assign ch_upper   = ahb_addr_in >> CH_SEL_LSB;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2) || done_ok;
  assign hit        = ahb_sel_in && ahb_readyin_in && can_accept;
  assign acc        = hit && ahb_trans_in[1];
  assign illegal    = (ahb_size_in > 3'(MAX_SIZE)) ||
                      ((ahb_addr_in[6:0] & size_mask(ahb_size_in)) != 7'd0) ||
                      (ch_upper >= AW'(NUM_CH)) ||
                      ((ahb_trans_in == TRANS_SEQ) && (!burst_open || (ahb_addr_in != exp_addr)));
  assign legal      = acc && !illegal;

  always_comb begin
    state_d       = state_q;
    ahb_ready_out = 1'b1;
    ahb_resp_out  = 1'b0;
    ahb_rdata_out = '0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        ahb_resp_out = (state_q == ST_ERR2);
        state_d      = acc ? (illegal ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
      end
      ST_ACCESS: begin
        ahb_ready_out = done_ok;
        if (done_ok && !write_q) ahb_rdata_out = sel_rdata;
        if (done_ok)                    state_d = acc ? (illegal ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
        else if (done_err || timeout)   state_d = ST_ERR1;
      end
      ST_ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
        state_d       = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      state_q <= ST_IDLE;
      ch_q    <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      wdata_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= legal;
      if (legal) begin
        ch_q    <= ch_upper[2:0];
        addr_q  <= ahb_addr_in;
        write_q <= ahb_write_in;
        size_q  <= ahb_size_in;
      end
      if ((state_q == ST_ACCESS) && first_q) wdata_q <= ahb_wdata_in;
    end
  end

  ahb_burst_addr_gen #(
    .AHB_ADDR_WIDTH(AW)
  ) u_burst (
    .ahb_clk_in (ahb_clk_in),
    .ahb_rstn_in(ahb_rstn_in),
    .load       (legal && (ahb_trans_in == TRANS_NONSEQ)),
    .advance    (legal && (ahb_trans_in == TRANS_SEQ)),
    .abort      ((hit && (ahb_trans_in == TRANS_IDLE)) || (state_d == ST_ERR1)),
    .addr       (ahb_addr_in),
    .burst      (ahb_burst_in),
    .size       (ahb_size_in),
    .burst_open (burst_open),
    .next_addr  (exp_addr)
  );

  always_comb begin
    other_sel_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((state_q == ST_ACCESS) && (ch_q == 3'(c))) other_sel_out[c] = 1'b1;
    end
  end

  // Write data is live on the first data-phase cycle, then held from the capture register.
  assign other_wdata_out = ((state_q == ST_ACCESS) && first_q) ? ahb_wdata_in : wdata_q;
  assign other_addr_out  = addr_q;
  assign other_write_out = write_q;
  assign other_size_out  = size_q;

endmodule
